// File: rtl/delay_timer.sv
// One-shot delay timer: an accepted start on enable yields a single-cycle done pulse
// N clock cycles later, where N is DELAY_TIME converted to cycles at elaboration.
module delay_timer #(
    parameter int CLOCK_CYCLE_TIME = 10,
    parameter int DELAY_TIME       = 30,
    parameter int ROUND_MODE       = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic enable,
    output logic done
);

    localparam int CYC = (CLOCK_CYCLE_TIME > 0) ? CLOCK_CYCLE_TIME : 1;
    localparam int N   = (ROUND_MODE == 0) ? (DELAY_TIME / CYC)
                                           : ((DELAY_TIME + CYC - 1) / CYC);
    localparam int CW  = (N <= 1) ? 1 : $clog2(N + 1);

    typedef enum logic {
        IDLE,
        COUNT
    } state_t;

    generate
        if (CLOCK_CYCLE_TIME <= 0) begin : g_bad_cycle
            $error("delay_timer: CLOCK_CYCLE_TIME must be > 0");
        end
        if (ROUND_MODE != 0 && ROUND_MODE != 1) begin : g_bad_round
            $error("delay_timer: ROUND_MODE must be 0 or 1");
        end

        if (N == 0) begin : g_zero
            assign done = enable & ~rst;
        end else begin : g_count
            state_t         state, state_next;
            logic [CW-1:0]  cnt, cnt_next;
            logic           done_next;

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    state <= IDLE;
                    cnt   <= '0;
                    done  <= 1'b0;
                end else begin
                    state <= state_next;
                    cnt   <= cnt_next;
                    done  <= done_next;
                end
            end

            // cnt holds the number of edges left; the edge that sees 1 is E0+N
            always_comb begin
                state_next = state;
                cnt_next   = cnt;
                case (state)
                    IDLE: begin
                        if (enable) begin
                            state_next = COUNT;
                            cnt_next   = CW'(N);
                        end
                    end
                    COUNT: begin
                        cnt_next = cnt - CW'(1);
                        if (cnt == CW'(1)) begin
                            state_next = IDLE;
                        end
                    end
                    default: begin
                        state_next = IDLE;
                        cnt_next   = '0;
                    end
                endcase
            end

            always_comb begin
                done_next = (state == COUNT) && (cnt == CW'(1));
            end
        end
    endgenerate

endmodule

// File: tb/tb_delay_timer.sv
// Directed bench for delay_timer: default N=3, rounding of 25/10 both ways,
// retrigger, asynchronous reset and zero-delay pass-through.
module tb_delay_timer;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic en_a = 1'b0;
    logic en_b = 1'b0;
    logic en_z = 1'b0;
    logic done_a, done_r1, done_r0, done_z;

    int unsigned vectors = 0;
    int unsigned miscompares = 0;

    always #5 clk = ~clk;

    delay_timer #(.CLOCK_CYCLE_TIME(10), .DELAY_TIME(30), .ROUND_MODE(1)) u_a (
        .clk(clk), .rst(rst), .enable(en_a), .done(done_a));
    delay_timer #(.CLOCK_CYCLE_TIME(10), .DELAY_TIME(25), .ROUND_MODE(1)) u_r1 (
        .clk(clk), .rst(rst), .enable(en_b), .done(done_r1));
    delay_timer #(.CLOCK_CYCLE_TIME(10), .DELAY_TIME(25), .ROUND_MODE(0)) u_r0 (
        .clk(clk), .rst(rst), .enable(en_b), .done(done_r0));
    delay_timer #(.CLOCK_CYCLE_TIME(10), .DELAY_TIME(0), .ROUND_MODE(1)) u_z (
        .clk(clk), .rst(rst), .enable(en_z), .done(done_z));

    task automatic check(input string tag, input logic obs, input logic exp);
        vectors++;
        if (obs !== exp) begin
            miscompares++;
            $display("FAIL %s: got %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        // reset held across the first edge
        #12;
        check("rst_a", done_a, 1'b0);
        check("rst_r1", done_r1, 1'b0);
        check("rst_r0", done_r0, 1'b0);
        check("rst_z", done_z, 1'b0);
        rst = 1'b0;
        step();

        // 1: single start, done only between E0+3 and E0+4
        en_a = 1'b1;
        step();
        en_a = 1'b0;
        check("t1_e0", done_a, 1'b0);
        for (int k = 1; k <= 7; k++) begin
            step();
            check($sformatf("t1_c%0d", k), done_a, k == 3);
        end

        // 2: second start 8 cycles after the first
        en_a = 1'b1;
        step();
        en_a = 1'b0;
        for (int k = 1; k <= 6; k++) begin
            step();
            check($sformatf("t2_c%0d", k), done_a, k == 3);
        end

        // 3: 25/10 rounds to 3 (ceil) and 2 (floor)
        en_b = 1'b1;
        step();
        en_b = 1'b0;
        for (int k = 1; k <= 5; k++) begin
            step();
            check($sformatf("t3_ceil_c%0d", k), done_r1, k == 3);
            check($sformatf("t3_floor_c%0d", k), done_r0, k == 2);
        end

        // 4a: enable pulsed again at E0+1 and E0+2 is ignored
        en_a = 1'b1;
        step();
        for (int k = 1; k <= 6; k++) begin
            en_a = (k <= 2);
            step();
            check($sformatf("t4a_c%0d", k), done_a, k == 3);
        end
        en_a = 1'b0;

        // 4b: enable held, one pulse every 4 cycles; last start sampled at E0+12
        en_a = 1'b1;
        step();
        for (int k = 1; k <= 16; k++) begin
            step();
            if (k == 12) en_a = 1'b0;
            check($sformatf("t4b_c%0d", k), done_a, (k % 4) == 3);
        end

        // 5: async reset between E0+1 and E0+2 aborts the run
        en_a = 1'b1;
        step();
        en_a = 1'b0;
        step();
        check("t5_e1", done_a, 1'b0);
        #2 rst = 1'b1;
        #1 check("t5_rst", done_a, 1'b0);
        #2 rst = 1'b0;
        for (int k = 2; k <= 6; k++) begin
            step();
            check($sformatf("t5_abort_c%0d", k), done_a, 1'b0);
        end
        en_a = 1'b1;
        step();
        en_a = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            step();
            check($sformatf("t5_new_c%0d", k), done_a, k == 3);
        end

        // 5b: reset while done is high clears it without waiting for an edge
        en_a = 1'b1;
        step();
        en_a = 1'b0;
        step();
        step();
        step();
        check("t5b_pre", done_a, 1'b1);
        #2 rst = 1'b1;
        #1 check("t5b_rst", done_a, 1'b0);
        #2 rst = 1'b0;
        step();
        check("t5b_post", done_a, 1'b0);

        // 6: zero-delay pass-through
        en_z = 1'b1;
        #1 check("t6_on", done_z, 1'b1);
        step();
        check("t6_held", done_z, 1'b1);
        rst = 1'b1;
        #1 check("t6_rst", done_z, 1'b0);
        rst = 1'b0;
        #1 check("t6_rel", done_z, 1'b1);
        en_z = 1'b0;
        #1 check("t6_off", done_z, 1'b0);
        check("t6_a_quiet", done_a, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/delay_timer.md
Name: delay_timer

Overview:
- One-shot delay timer: a start request on `enable` produces a single-cycle `done` pulse a fixed time later.
- The delay is specified in time units and converted at elaboration to a whole number of clock cycles, using a selectable rounding rule.
- Used as a generic building block wherever a control FSM must wait a fixed, time-specified interval (settling, setup/hold waits, pacing) before proceeding.

Parameters:
- CLOCK_CYCLE_TIME, default 10: period of `clk` in time units (e.g. ns); integer, must be > 0.
- DELAY_TIME, default 30: requested delay in the same time units; integer, >= 0; 0 selects zero-delay mode.
- ROUND_MODE, default 1: 0 = round down (floor), 1 = round up (ceiling) when DELAY_TIME is not a multiple of CLOCK_CYCLE_TIME.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-high reset.
- enable  input  1  start request; sampled on rising edge of `clk`.
- done  output  1  single-cycle completion pulse.

Behaviour:
- Derived constant N (elaboration time):
  - ROUND_MODE=0: N = floor(DELAY_TIME / CLOCK_CYCLE_TIME).
  - ROUND_MODE=1: N = ceil(DELAY_TIME / CLOCK_CYCLE_TIME).
  - Any other ROUND_MODE value, or CLOCK_CYCLE_TIME <= 0: elaboration error.
- Counter width: max(1, clog2(N+1)); the counter never wraps.
- Reset: while `rst`=1, state=IDLE, counter=0, `done`=0 immediately (asynchronous). Reset mid-count aborts the run with no `done` pulse.
- States: IDLE, COUNT.
- IDLE:
  - On an edge E0 with `enable`=1, load counter and go to COUNT.
  - `enable`=0 stays in IDLE.
- COUNT:
  - Counter advances once per edge.
  - `done` is a registered output: high from edge E0+N until edge E0+N+1, exactly one clock cycle.
  - At edge E0+N the block returns to IDLE.
- Retrigger:
  - `enable` sampled at edges E0+1..E0+N is ignored; no restart and no extension.
  - `enable` sampled at edge E0+N+1 or later starts a new run. This allows back-to-back runs with a period of N+1 cycles.
- Level vs. pulse: `enable` is level-sampled only in IDLE. Holding it high gives repeated runs, one `done` pulse every N+1 cycles.
- N=1: `done` is high during the cycle after edge E0+1.
- N=0 (zero-delay mode): `done` = `enable` AND NOT `rst`, combinational pass-through. No state is used and a held `enable` gives a held `done`.
- Edge case: DELAY_TIME < CLOCK_CYCLE_TIME with ROUND_MODE=0 yields N=0, i.e. zero-delay mode.
- `done` never asserts without a preceding accepted start.

Test Plan:
1. Defaults (10/30/1, N=3): reset, then one-cycle `enable` at edge E0 -> `done`=1 only between E0+3 and E0+4; `done`=0 at all other times.
2. Second pulse 8 cycles after the first start -> second `done` pulse exactly 3 cycles after its start edge; no extra pulses.
3. Rounding with DELAY_TIME=25, CLOCK_CYCLE_TIME=10:
   - ROUND_MODE=1 -> N=3, `done` at E0+3.
   - ROUND_MODE=0 -> N=2, `done` at E0+2.
4. Retrigger with N=3: `enable` pulsed again at E0+1 and E0+2 -> single `done` at E0+3 only; `enable` held high continuously -> `done` pulses at E0+3, E0+7, E0+11.
5. Reset mid-run: assert `rst` asynchronously between E0+1 and E0+2 -> `done`=0 immediately and no pulse follows. After release, a new `enable` produces `done` 3 cycles later.
6. Zero-delay (DELAY_TIME=0): `done` follows `enable` combinationally with the same width; `rst`=1 forces `done`=0.
